flash_audio_sequencer: RTL and testbench
========================================

// Module: flash_audio_sequencer
// PURPOSE
//  Sequences 32-bit word reads from the audio flash (Avalon-MM read master) and emits 16-bit samples at the sample rate.
//  Playback follows the 2-bit direction command from the keyboard controller: play/pause, forward/backward, restart.
//  Sits between the keyboard FSM, the sample-rate tick generator and the flash controller; feeds the audio DAC path.
// PARAMETERS
//  ADDR_W    23         flash word-address width
//  MAX_ADDR  23'h7FFFF  last word of the song; the address wraps between MAX_ADDR and 0
// PORTS
//  clk                  in   1       system clock, single clock domain
//  reset                in   1       asynchronous, active-high
//  direction            in   2       [1]=play(1)/pause(0), [0]=forward(1)/backward(0), level from keyboard FSM
//  restart              in   1       1-cycle pulse: jump to song start (forward) or song end (backward)
//  sample_tick          in   1       1-cycle pulse at sample rate, already synchronous to clk
//  flash_waitrequest    in   1       Avalon waitrequest
//  flash_readdatavalid  in   1       Avalon readdatavalid
//  flash_readdata       in   32      Avalon read data
//  flash_read           out  1       Avalon read strobe
//  flash_address        out  ADDR_W  current word address
//  flash_byteenable     out  4       constant 4'b1111
//  audio_sample         out  16      current sample, held between updates
//  sample_valid         out  1       1-cycle pulse when audio_sample updates
// BEHAVIOUR
//  Reset: state IDLE, flash_address=0, flash_read=0, audio_sample=0, sample_valid=0, latched dir=forward, restart_pend=0.
//  States: IDLE -> REQ -> WAIT_DATA -> SAMPLE_A -> WAIT_TICK2 -> SAMPLE_B -> IDLE.
//  IDLE: sample_tick && direction[1] -> REQ next cycle; latch direction[0] as word_dir.
//  REQ: flash_read=1, address stable; held while waitrequest=1; cycle with waitrequest=0 -> WAIT_DATA, read drops.
//  WAIT_DATA: on readdatavalid, latch word -> SAMPLE_A (or IDLE if restart_pend; see restart).
//  SAMPLE_A: audio_sample = word_dir ? word[15:0] : word[31:16]; sample_valid=1 for one cycle -> WAIT_TICK2.
//  WAIT_TICK2: sample_tick && direction[1] -> SAMPLE_B.
//  SAMPLE_B: audio_sample = other half; sample_valid=1; address steps per word_dir -> IDLE.
//  Latency: readdatavalid at cycle N -> audio_sample/sample_valid at N+1; tick at N -> SAMPLE_B output at N+1.
//  Address step: forward: addr==MAX_ADDR ? 0 : addr+1; backward: addr==0 ? MAX_ADDR : addr-1 (unsigned, ADDR_W bits).
//  Direction change takes effect at the next word boundary; the current word keeps word_dir for both order and step.
//  Pause (direction[1]=0): ticks ignored in IDLE/WAIT_TICK2; audio_sample held; in-flight read completes (no abort),
//   SAMPLE_A still emitted, then waits in WAIT_TICK2.
//  sample_tick in REQ/WAIT_DATA/SAMPLE_A/SAMPLE_B: ignored (dropped, no queueing).
//  Restart in IDLE/WAIT_TICK2/SAMPLE_A/SAMPLE_B: address <= direction[0] ? 0 : MAX_ADDR next cycle; state -> IDLE;
//   no sample_valid from SAMPLE_B when restart coincides (restart wins over step).
//  Restart in REQ/WAIT_DATA: set restart_pend; on readdatavalid discard word (no sample_valid), load restart
//   address per current direction[0], clear pend, -> IDLE.
//  Restart and readdatavalid in same cycle of WAIT_DATA: treated as pending restart (word discarded).
//  Async reset mid-transaction: all state cleared immediately; a late readdatavalid in IDLE is ignored.
//  flash_read is a registered output; never asserted outside REQ.
// STRUCTURE
//  Shared include/package: state encodings, DIR_PLAY_BIT=1, DIR_FWD_BIT=0, keyboard ASCII code defines.
//  One sub-module: wrap_addr_counter (up/down, load, wrap at MAX_ADDR/0), parameterised by ADDR_W, MAX_ADDR.
//  FSM + sample mux + restart_pend register live in this module.
// TESTING
//  1 Play fwd, addr 0, word 32'hAAAA_5555, waitrequest 2 cycles -> read held 3 cycles, samples 5555 then AAAA, addr=1.
//  2 Play bwd at addr 0, word 32'h1234_5678 -> samples 1234 then 5678, addr wraps to 23'h7FFFF.
//  3 Play fwd at addr 23'h7FFFF -> after SAMPLE_B addr=0; no glitch in flash_read.
//  4 Pause after SAMPLE_A -> 10 ticks produce no sample_valid, audio_sample held; resume -> SAMPLE_B on next tick.
//  5 Restart pulse during WAIT_DATA, dir fwd, addr 23'h100 -> word discarded, no sample_valid, addr=0, state IDLE.
//  6 Assert reset during REQ -> flash_read=0, addr=0, audio_sample=0 same cycle; readdatavalid afterwards ignored.

Source files
------------

// File: rtl/flash_audio_sequencer_pkg.sv
// Shared definitions for the flash audio sequencer: FSM states, direction command bit
// positions, data widths and the keyboard codes the keyboard FSM turns into commands.
package flash_audio_sequencer_pkg;

    localparam int DIR_PLAY_BIT = 1;
    localparam int DIR_FWD_BIT  = 0;

    localparam int WORD_W   = 32;
    localparam int SAMPLE_W = 16;

    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_REQ        = 3'd1,
        ST_WAIT_DATA  = 3'd2,
        ST_SAMPLE_A   = 3'd3,
        ST_WAIT_TICK2 = 3'd4,
        ST_SAMPLE_B   = 3'd5
    } seq_state_e;

    // ASCII keys decoded upstream: E play, D pause, F forward, B backward, R restart.
    typedef enum logic [7:0] {
        KEY_B = 8'h42,
        KEY_D = 8'h44,
        KEY_E = 8'h45,
        KEY_F = 8'h46,
        KEY_R = 8'h52
    } kbd_key_e;

    function automatic logic [SAMPLE_W-1:0] pick_half(input logic [WORD_W-1:0] word,
                                                      input logic              low_half);
        return low_half ? word[SAMPLE_W-1:0] : word[WORD_W-1:SAMPLE_W];
    endfunction

endpackage

// File: rtl/flash_audio_sequencer_wrap_addr_counter.sv
// Up/down word-address counter with synchronous load that wraps between MAX_ADDR and 0.
module wrap_addr_counter #(
    parameter int unsigned       ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              step_en,
    input  logic              step_up,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;

    // Load has priority so a restart always overrides a pending step.
    always_comb begin
        addr_d = addr_q;
        if (load_en) begin
            addr_d = load_addr;
        end else if (step_en) begin
            if (step_up) begin
                addr_d = (addr_q == MAX_ADDR) ? '0 : addr_q + ADDR_W'(1);
            end else begin
                addr_d = (addr_q == '0) ? MAX_ADDR : addr_q - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/flash_audio_sequencer.sv
// Reads 32-bit words from the audio flash and plays them out as two 16-bit samples on
// successive sample ticks, following the keyboard play/pause/direction/restart command.
module flash_audio_sequencer #(
    parameter int unsigned       ADDR_W   = 23,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 23'h7FFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        direction,
    input  logic              restart,
    input  logic              sample_tick,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [31:0]       flash_readdata,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_address,
    output logic [3:0]        flash_byteenable,
    output logic [15:0]       audio_sample,
    output logic              sample_valid,
    output logic [2:0]        dbg_state
);

    import flash_audio_sequencer_pkg::*;

    // Avalon read: the request is taken on a cycle where flash_read=1 and
    // flash_waitrequest=0; exactly one readdatavalid beat follows later.

    seq_state_e          state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                word_dir_q, word_dir_d;
    logic [SAMPLE_W-1:0] audio_sample_q, audio_sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                flash_read_q, flash_read_d;
    logic                restart_pend_q, restart_pend_d;

    logic                addr_load;
    logic                addr_step;
    logic [ADDR_W-1:0]   restart_addr;
    logic                tick_play;

    assign tick_play    = sample_tick & direction[DIR_PLAY_BIT];
    assign restart_addr = direction[DIR_FWD_BIT] ? '0 : MAX_ADDR;

    always_comb begin
        state_d        = state_q;
        word_d         = word_q;
        word_dir_d     = word_dir_q;
        audio_sample_d = audio_sample_q;
        sample_valid_d = 1'b0;
        restart_pend_d = restart_pend_q;
        addr_load      = 1'b0;
        addr_step      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (restart) begin
                    addr_load = 1'b1;
                end else if (tick_play) begin
                    state_d    = ST_REQ;
                    word_dir_d = direction[DIR_FWD_BIT];
                end
            end
            ST_REQ: begin
                // A read already on the bus cannot be withdrawn; remember the restart.
                if (restart) begin
                    restart_pend_d = 1'b1;
                end
                if (!flash_waitrequest) begin
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (flash_readdatavalid) begin
                    if (restart_pend_q || restart) begin
                        addr_load      = 1'b1;
                        restart_pend_d = 1'b0;
                        state_d        = ST_IDLE;
                    end else begin
                        word_d         = flash_readdata;
                        audio_sample_d = pick_half(flash_readdata, word_dir_q);
                        sample_valid_d = 1'b1;
                        state_d        = ST_SAMPLE_A;
                    end
                end else if (restart) begin
                    restart_pend_d = 1'b1;
                end
            end
            ST_SAMPLE_A: begin
                if (restart) begin
                    addr_load = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_TICK2;
                end
            end
            ST_WAIT_TICK2: begin
                if (restart) begin
                    addr_load = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tick_play) begin
                    audio_sample_d = pick_half(word_q, !word_dir_q);
                    sample_valid_d = 1'b1;
                    state_d        = ST_SAMPLE_B;
                end
            end
            ST_SAMPLE_B: begin
                // The step uses the direction latched for this word, not the live command.
                state_d = ST_IDLE;
                if (restart) begin
                    addr_load = 1'b1;
                end else begin
                    addr_step = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flash_read_d = (state_d == ST_REQ);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            word_q         <= '0;
            word_dir_q     <= 1'b1;
            audio_sample_q <= '0;
            sample_valid_q <= 1'b0;
            flash_read_q   <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            word_q         <= word_d;
            word_dir_q     <= word_dir_d;
            audio_sample_q <= audio_sample_d;
            sample_valid_q <= sample_valid_d;
            flash_read_q   <= flash_read_d;
            restart_pend_q <= restart_pend_d;
        end
    end

    wrap_addr_counter #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR)
    ) u_addr (
        .clk       (clk),
        .rst       (reset),
        .load_en   (addr_load),
        .load_addr (restart_addr),
        .step_en   (addr_step),
        .step_up   (word_dir_q),
        .addr      (flash_address)
    );

    assign flash_read       = flash_read_q;
    assign flash_byteenable = BYTEENABLE_ALL;
    assign audio_sample     = audio_sample_q;
    assign sample_valid     = sample_valid_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_flash_audio_sequencer.sv
// Bench for flash_audio_sequencer: directed scenarios plus randomized playback against a
// word-level reference model, with a reactive Avalon flash responder.
module tb_flash_audio_sequencer;
    import flash_audio_sequencer_pkg::*;

    localparam logic [22:0] MAX_ADDR = 23'h7FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  direction;
    logic        restart;
    logic        sample_tick;
    logic        flash_waitrequest = 1'b0;
    logic        flash_readdatavalid = 1'b0;
    logic [31:0] flash_readdata = 32'h0;
    logic        flash_read;
    logic [22:0] flash_address;
    logic [3:0]  flash_byteenable;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic [2:0]  dbg_state;

    flash_audio_sequencer #(.ADDR_W(23), .MAX_ADDR(MAX_ADDR)) dut (
        .clk                 (clk),
        .reset               (reset),
        .direction           (direction),
        .restart             (restart),
        .sample_tick         (sample_tick),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .flash_read          (flash_read),
        .flash_address       (flash_address),
        .flash_byteenable    (flash_byteenable),
        .audio_sample        (audio_sample),
        .sample_valid        (sample_valid),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- flash contents ----------------
    logic [31:0] mem_over [int];

    function automatic logic [31:0] mem_word(input logic [22:0] a);
        if (mem_over.exists(int'(a))) return mem_over[int'(a)];
        return ({9'd0, a} * 32'h0001_9E37) ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [22:0] next_addr(input logic [22:0] a, input bit fwd);
        if (fwd) return (a == MAX_ADDR) ? 23'd0 : a + 23'd1;
        return (a == 23'd0) ? MAX_ADDR : a - 23'd1;
    endfunction

    // ---------------- reference model ----------------
    logic [22:0] m_addr;
    logic [15:0] m_sample;
    logic        m_valid, m_read;
    bit          m_in_read, m_granted, m_just_first, m_just_second, m_pend, m_dir;
    logic [15:0] m_second [$];

    always @(posedge clk or posedge reset) begin
        logic [22:0] ra;
        logic [31:0] w;
        bit          emit;
        if (reset) begin
            m_addr = '0; m_sample = '0; m_valid = 1'b0; m_read = 1'b0;
            m_in_read = 0; m_granted = 0; m_just_first = 0; m_just_second = 0;
            m_pend = 0; m_dir = 1; m_second.delete();
        end else begin
            emit = 0;
            ra = direction[0] ? 23'd0 : MAX_ADDR;
            if (m_just_second) begin
                m_just_second = 0;
                m_addr = restart ? ra : next_addr(m_addr, m_dir);
            end else if (m_just_first) begin
                m_just_first = 0;
                if (restart) begin m_addr = ra; m_second.delete(); end
            end else if (m_second.size() != 0) begin
                if (restart) begin
                    m_addr = ra; m_second.delete();
                end else if (sample_tick && direction[1]) begin
                    m_sample = m_second.pop_front(); emit = 1; m_just_second = 1;
                end
            end else if (m_in_read) begin
                if (!m_granted) begin
                    if (restart) m_pend = 1;
                    if (!flash_waitrequest) m_granted = 1;
                end else if (flash_readdatavalid) begin
                    m_in_read = 0; m_granted = 0;
                    if (m_pend || restart) begin
                        m_addr = ra; m_pend = 0;
                    end else begin
                        w = mem_word(m_addr);
                        m_sample = m_dir ? w[15:0] : w[31:16];
                        m_second.push_back(m_dir ? w[31:16] : w[15:0]);
                        emit = 1; m_just_first = 1;
                    end
                end else if (restart) begin
                    m_pend = 1;
                end
            end else begin
                if (restart) m_addr = ra;
                else if (sample_tick && direction[1]) begin m_in_read = 1; m_dir = direction[0]; end
            end
            m_valid = emit;
            m_read  = m_in_read && !m_granted;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("flash_read", flash_read, m_read);
            check("flash_address", flash_address, m_addr);
            check("sample_valid", sample_valid, m_valid);
            check("audio_sample", audio_sample, m_sample);
            check("flash_byteenable", flash_byteenable, 4'hF);
        end
    end

    // ---------------- observation for directed tests ----------------
    int          read_hi_cnt = 0;
    logic [15:0] cap_q [$];

    always @(negedge clk) begin
        if (!reset) begin
            if (flash_read) read_hi_cnt++;
            if (sample_valid) cap_q.push_back(audio_sample);
        end
    end

    function automatic logic [15:0] cap_at(input int i);
        if (i < cap_q.size()) return cap_q[i];
        return 16'hxxxx;
    endfunction

    // ---------------- flash responder ----------------
    int          wr_fixed = -1, lat_fixed = -1;
    int          wr_cnt = 0, wr_target = 0, resp_cnt = 0;
    bit          resp_busy = 0, inject_rdv = 0;
    logic [22:0] resp_addr = '0;

    always begin
        @(posedge clk); #2;
        flash_readdatavalid = 1'b0;
        if (reset) begin
            resp_busy = 0; wr_cnt = 0; flash_waitrequest = 1'b0;
        end else begin
            if (inject_rdv) begin
                flash_readdatavalid = 1'b1; flash_readdata = 32'hDEAD_BEEF; inject_rdv = 0;
            end else if (resp_busy) begin
                if (resp_cnt == 0) begin
                    flash_readdatavalid = 1'b1; flash_readdata = mem_word(resp_addr); resp_busy = 0;
                end else begin
                    resp_cnt--;
                end
            end
            if (flash_read) begin
                if (wr_cnt == 0) wr_target = (wr_fixed >= 0) ? wr_fixed : $urandom_range(0, 3);
                if (wr_cnt < wr_target) begin
                    flash_waitrequest = 1'b1; wr_cnt++;
                end else begin
                    flash_waitrequest = 1'b0; wr_cnt = 0; resp_busy = 1;
                    resp_addr = flash_address;
                    resp_cnt = (lat_fixed >= 0) ? lat_fixed : $urandom_range(0, 3);
                end
            end else begin
                flash_waitrequest = 1'b0; wr_cnt = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk); #2;
    endtask

    task automatic tick_pulse();
        sample_tick = 1'b1; cycle(); sample_tick = 1'b0;
    endtask

    task automatic restart_pulse();
        restart = 1'b1; cycle(); restart = 1'b0;
    endtask

    task automatic wait_caps(input int n, input string name);
        int k = 0;
        while (cap_q.size() < n && k < 60) begin cycle(); k++; end
        check({name, "_arrived"}, (cap_q.size() >= n), 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        reset = 1'b1; direction = 2'b01; restart = 1'b0; sample_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read", flash_read, 1'b0);
        check("rst_addr", flash_address, 23'd0);
        check("rst_sample", audio_sample, 16'd0);
        check("rst_valid", sample_valid, 1'b0);
        check("rst_byteenable", flash_byteenable, 4'hF);
        check("rst_state", dbg_state, ST_IDLE);
        cycle(); reset = 1'b0; cycle();

        // forward play, two waitrequest cycles
        mem_over[0] = 32'hAAAA_5555; wr_fixed = 2; lat_fixed = 1;
        direction = 2'b11; read_hi_cnt = 0; cap_q.delete();
        tick_pulse();
        wait_caps(1, "t1_a");
        check("t1_read_cycles", read_hi_cnt, 3);
        check("t1_sample_a", cap_at(0), 16'h5555);
        tick_pulse();
        wait_caps(2, "t1_b");
        check("t1_sample_b", cap_at(1), 16'hAAAA);
        @(negedge clk);
        check("t1_addr", flash_address, 23'd1);

        // backward play from 0 wraps to the end of the song
        restart_pulse(); cycle();
        @(negedge clk);
        check("t2_restart_addr", flash_address, 23'd0);
        mem_over[0] = 32'h1234_5678; direction = 2'b10; cap_q.delete(); wr_fixed = 0;
        tick_pulse(); wait_caps(1, "t2_a");
        check("t2_sample_a", cap_at(0), 16'h1234);
        tick_pulse(); wait_caps(2, "t2_b");
        check("t2_sample_b", cap_at(1), 16'h5678);
        @(negedge clk);
        check("t2_addr", flash_address, MAX_ADDR);

        // forward from the last word wraps to 0
        mem_over[int'(MAX_ADDR)] = 32'hCAFE_F00D; direction = 2'b11; read_hi_cnt = 0; cap_q.delete();
        tick_pulse(); wait_caps(1, "t3_a");
        check("t3_sample_a", cap_at(0), 16'hF00D);
        tick_pulse(); wait_caps(2, "t3_b");
        check("t3_sample_b", cap_at(1), 16'hCAFE);
        @(negedge clk);
        check("t3_addr", flash_address, 23'd0);
        check("t3_read_cycles", read_hi_cnt, 1);

        // pause between the two halves
        mem_over[0] = 32'h0BAD_BEEF; cap_q.delete();
        tick_pulse(); wait_caps(1, "t4_a");
        check("t4_sample_a", cap_at(0), 16'hBEEF);
        direction = 2'b01;
        repeat (10) begin tick_pulse(); cycle(); end
        check("t4_paused_count", cap_q.size(), 1);
        @(negedge clk);
        check("t4_held", audio_sample, 16'hBEEF);
        direction = 2'b11;
        tick_pulse(); wait_caps(2, "t4_b");
        check("t4_sample_b", cap_at(1), 16'h0BAD);
        @(negedge clk);
        check("t4_addr", flash_address, 23'd1);

        // play forward up to address 0x100
        wr_fixed = -1; lat_fixed = -1; cap_q.delete();
        for (int i = 0; i < 255; i++) begin
            tick_pulse(); wait_caps(2 * i + 1, "ff_a");
            tick_pulse(); wait_caps(2 * i + 2, "ff_b");
        end
        @(negedge clk);
        check("ff_addr", flash_address, 23'h100);

        // restart while waiting for read data
        wr_fixed = 0; lat_fixed = 4; read_hi_cnt = 0; cap_q.delete();
        tick_pulse();
        k = 0;
        while (!(read_hi_cnt > 0 && !flash_read) && k < 20) begin cycle(); k++; end
        check("t5_read_done", (read_hi_cnt > 0 && !flash_read), 1'b1);
        restart_pulse();
        repeat (10) cycle();
        check("t5_no_sample", cap_q.size(), 0);
        check("t5_addr", flash_address, 23'd0);
        check("t5_state", dbg_state, ST_IDLE);

        // reset in the middle of a read request
        lat_fixed = -1; direction = 2'b10;
        restart_pulse();
        wr_fixed = 6;
        tick_pulse();
        k = 0;
        while (!flash_read && k < 10) begin cycle(); k++; end
        check("t6_in_req", flash_read, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_read", flash_read, 1'b0);
        check("t6_addr", flash_address, 23'd0);
        check("t6_sample", audio_sample, 16'd0);
        check("t6_valid", sample_valid, 1'b0);
        cycle(); cycle();
        reset = 1'b0; inject_rdv = 1; cap_q.delete();
        repeat (5) cycle();
        check("t6_late_rdv_ignored", cap_q.size(), 0);
        check("t6_state", dbg_state, ST_IDLE);
        check("t6_read_idle", flash_read, 1'b0);

        // randomized playback
        wr_fixed = -1; lat_fixed = -1; direction = 2'b11; cap_q.delete();
        for (int i = 0; i < 4000; i++) begin
            sample_tick = ($urandom_range(0, 2) == 0);
            restart = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 29) == 0) direction = 2'($urandom_range(0, 3));
            cycle();
        end
        sample_tick = 1'b0; restart = 1'b0;
        repeat (5) cycle();
        check("rand_activity", (cap_q.size() > 50), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
